// File: rtl/spi_pkg.sv
// Shared definitions for the SPI receive-word sink.
// Holds the handshake FSM state type and the default word width and LED command codes.
package spi_pkg;

    localparam int unsigned SpiWordLen    = 8;
    localparam int unsigned SpiLedOnCode  = 7;
    localparam int unsigned SpiLedOffCode = 15;

    typedef enum logic [1:0] {
        StArm        = 2'd0,
        StWaitAccept = 2'd1,
        StBusy       = 2'd2
    } sink_state_e;

endpackage

// File: rtl/spi_word_fifo.sv
// Show-ahead FIFO with an exact occupancy count.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   wr_en_i, wr_data_i push request and data
//   rd_en_i            pop request (ignored while empty)
//   rd_data_o          head word, valid while rd_valid_o is high
//   rd_valid_o         FIFO not empty
//   count_o            occupancy, 0..Depth
//   drop_o             push rejected because full with no pop on the same edge
module spi_word_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         wr_en_i,
    input  logic [Width-1:0]             wr_data_i,
    input  logic                         rd_en_i,
    output logic [Width-1:0]             rd_data_o,
    output logic                         rd_valid_o,
    output logic [$clog2(Depth+1)-1:0]   count_o,
    output logic                         drop_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             empty, full, push, pop;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CntW'(Depth));
    assign pop    = rd_en_i & ~empty;
    // A pop on the same edge frees the slot the push needs.
    assign push   = wr_en_i & (~full | pop);
    assign drop_o = wr_en_i & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Depth is a power of two, so pointer overflow is the modulo wrap.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o  = mem_q[rd_ptr_q];
    assign rd_valid_o = ~empty;
    assign count_o    = count_q;

endmodule

// File: rtl/spi_rx_word_sink.sv
// Downstream consumer for a slave-mode SPI word receiver.
// Runs the processing_word / process_next_word handshake so the slave keeps receiving
// back-to-back words and queues every completed word in a show-ahead FIFO.
// Optional feature macro: SPI_RX_SINK_LED_DECODE_EN (LED on/off command decode).
// Ports:
//   master_clock, do_reset_n   clock, asynchronous active-low reset
//   is_ready                   high from the first edge after reset release
//   processing_word            slave busy with a word
//   process_next_word          request the slave to receive the next word
//   data_word_recv             slave word, valid when processing_word falls
//   rd_data, rd_valid, rd_ready FIFO read port (pop on rd_valid & rd_ready)
//   fifo_count                 FIFO occupancy
//   overflow, clear_overflow   sticky dropped-word flag and its synchronous clear
//   led_out                    command-decoded indicator (0 when decode is disabled)
module spi_rx_word_sink
    import spi_pkg::*;
#(
    parameter int unsigned WORD_LEN     = SpiWordLen,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned LED_ON_CODE  = SpiLedOnCode,
    parameter int unsigned LED_OFF_CODE = SpiLedOffCode
) (
    input  logic                              master_clock,
    input  logic                              do_reset_n,
    output logic                              is_ready,
    input  logic                              processing_word,
    output logic                              process_next_word,
    input  logic [WORD_LEN-1:0]               data_word_recv,
    output logic [WORD_LEN-1:0]               rd_data,
    output logic                              rd_valid,
    input  logic                              rd_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              overflow,
    input  logic                              clear_overflow,
    output logic                              led_out
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (LED_ON_CODE == LED_OFF_CODE) begin : g_bad_led_codes
        $error("LED_ON_CODE and LED_OFF_CODE must differ");
    end

    sink_state_e state_q, state_d;
    logic        is_ready_q;
    logic        pnw_q, pnw_d;
    logic        overflow_q, overflow_d;
    logic        capture;
    logic        drop;

    // Handshake FSM. ARM also waits for the slave to be idle so that a word still in
    // flight across a reset is never mistaken for an accepted request.
    always_comb begin
        state_d = state_q;
        pnw_d   = pnw_q;
        capture = 1'b0;
        case (state_q)
            StArm: begin
                if (is_ready_q && !processing_word) begin
                    pnw_d   = 1'b1;
                    state_d = StWaitAccept;
                end
            end
            StWaitAccept: begin
                if (processing_word) begin
                    pnw_d   = 1'b0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (!processing_word) begin
                    capture = 1'b1;
                    state_d = StArm;
                end
            end
            default: begin
                pnw_d   = 1'b0;
                state_d = StArm;
            end
        endcase
    end

    // Set wins over a simultaneous clear.
    assign overflow_d = drop | (overflow_q & ~clear_overflow);

    always_ff @(posedge master_clock or negedge do_reset_n) begin
        if (!do_reset_n) begin
            state_q    <= StArm;
            is_ready_q <= 1'b0;
            pnw_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_ready_q <= 1'b1;
            pnw_q      <= pnw_d;
            overflow_q <= overflow_d;
        end
    end

    spi_word_fifo #(
        .Width (WORD_LEN),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (master_clock),
        .rst_ni     (do_reset_n),
        .wr_en_i    (capture),
        .wr_data_i  (data_word_recv),
        .rd_en_i    (rd_ready),
        .rd_data_o  (rd_data),
        .rd_valid_o (rd_valid),
        .count_o    (fifo_count),
        .drop_o     (drop)
    );

    assign is_ready          = is_ready_q;
    assign process_next_word = pnw_q;
    assign overflow          = overflow_q;

`ifdef SPI_RX_SINK_LED_DECODE_EN
    localparam logic [WORD_LEN-1:0] LedOnWord  = WORD_LEN'(LED_ON_CODE);
    localparam logic [WORD_LEN-1:0] LedOffWord = WORD_LEN'(LED_OFF_CODE);

    logic led_q, led_d;

    // Decodes every captured word, including ones the FIFO drops.
    always_comb begin
        led_d = led_q;
        if (capture) begin
            if (data_word_recv == LedOnWord) begin
                led_d = 1'b1;
            end else if (data_word_recv == LedOffWord) begin
                led_d = 1'b0;
            end
        end
    end

    always_ff @(posedge master_clock or negedge do_reset_n) begin
        if (!do_reset_n) begin
            led_q <= 1'b0;
        end else begin
            led_q <= led_d;
        end
    end

    assign led_out = led_q;
`else
    assign led_out = 1'b0;
`endif

endmodule

// File: doc/spi_rx_word_sink.md
Name: spi_rx_word_sink

Overview:
- Downstream consumer of the slave-mode spi_module.
- Runs the processing_word / process_next_word handshake so the slave keeps receiving back-to-back words.
- Captures each completed data_word_recv into a small show-ahead FIFO with a valid/ready read port.
- Optionally decodes LED on/off command words.
- Replaces ad-hoc handshake logic in top levels and benches.

Parameters:
- WORD_LEN, 8: SPI word width; must match the slave spi_module.
- FIFO_DEPTH, 4: FIFO entries; power of two, at least 2.
- LED_ON_CODE, 7: received word that sets led_out.
- LED_OFF_CODE, 15: received word that clears led_out.

Ports:
- master_clock  in  1  system clock; same clock as the slave spi_module.
- do_reset_n  in  1  asynchronous, active-low reset.
- is_ready  out  1  high once out of reset.
- processing_word  in  1  from slave; high while a word is in flight.
- process_next_word  out  1  to slave; request to receive the next word.
- data_word_recv  in  WORD_LEN  from slave; valid when processing_word falls.
- rd_data  out  WORD_LEN  FIFO head word.
- rd_valid  out  1  FIFO not empty.
- rd_ready  in  1  consumer pops the head when rd_valid is also high.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  occupancy.
- overflow  out  1  sticky; set when a word is dropped.
- clear_overflow  in  1  synchronous clear of overflow.
- led_out  out  1  command-decoded indicator.

Behaviour:
- Reset (do_reset_n low, asynchronous):
  - state = ARM; pointers and count = 0.
  - is_ready = 0, process_next_word = 0, rd_valid = 0, overflow = 0, led_out = 0.
  - rd_data is don't-care while rd_valid = 0.
- is_ready goes high on the first master_clock edge after do_reset_n rises; it then stays high.
- All inputs are synchronous to master_clock; no synchronisers are used.
- FSM, registered, evaluated on the rising edge:
  - ARM: process_next_word <= 1. Go to WAIT_ACCEPT. Only entered when is_ready = 1.
  - WAIT_ACCEPT: hold process_next_word = 1 until processing_word = 1. Then process_next_word <= 0 and go to BUSY.
  - BUSY: wait for processing_word = 0. On that edge, capture data_word_recv, then go to ARM.
- No word is captured before the first full WAIT_ACCEPT→BUSY cycle. Stale data_word_recv after reset is never pushed.
- Capture and push:
  - The captured word is written into the FIFO on the same edge.
  - rd_valid and rd_data reflect it on the next cycle (1-cycle latency when the FIFO was empty).
  - Minimum word-to-word loop is 3 cycles plus the slave's transfer time.
- FIFO:
  - Show-ahead: rd_data = mem[rd_ptr].
  - Pop when rd_valid & rd_ready. Pointers wrap modulo FIFO_DEPTH.
  - fifo_count is exact, 0..FIFO_DEPTH.
- Full:
  - A push with no simultaneous pop drops the word and sets overflow.
  - Push plus pop on the same edge while full: both succeed; count is unchanged.
- Empty: rd_ready is ignored. Push and rd_ready on the same edge only pushes.
- overflow:
  - Cleared by clear_overflow.
  - If a set and a clear happen on the same edge, set wins.
- Reset asserted mid-word aborts the FSM and empties the FIFO. After release, the block re-arms; the interrupted word is not captured.
- The handshake continues regardless of FIFO state (no backpressure to the SPI link).

Optional Feature:
- Macro: SPI_RX_SINK_LED_DECODE_EN.
- Defined:
  - On every capture, including dropped words: word == LED_ON_CODE sets led_out <= 1; word == LED_OFF_CODE clears led_out <= 0.
  - Any other word leaves led_out unchanged.
  - Decode updates on the capture edge.
- Undefined: led_out is tied 0 and no comparators are synthesised.

Decomposition:
- Shared package spi_pkg:
  - state enum (ARM, WAIT_ACCEPT, BUSY);
  - default WORD_LEN;
  - default LED_ON_CODE / LED_OFF_CODE constants.
- One sub-module: spi_word_fifo (parameterised show-ahead FIFO with count). The handshake FSM and decode stay in the top module.

Test Plan:
- Reset then idle slave (processing_word = 0):
  - process_next_word rises 2 cycles after reset release and stays high;
  - rd_valid stays 0;
  - no stale word is pushed.
- Slave sends 1, 2, 3 with rd_ready = 1 → rd_data sequence 1, 2, 3; each rd_valid pulse starts 1 cycle after its processing_word fall; fifo_count never exceeds 1.
- rd_ready = 0, 6 words 0xA0..0xA5 with FIFO_DEPTH = 4:
  - fifo_count = 4 and overflow = 1;
  - draining yields 0xA0..0xA3.
- Full FIFO, capture edge coincides with rd_ready = 1 → no overflow; count stays 4; new word appears last.
- With SPI_RX_SINK_LED_DECODE_EN, send 7, 3, 15, 7:
  - led_out goes 1, 1, 0, 1, updating on each capture edge;
  - without the macro, led_out = 0 throughout.
- Assert do_reset_n low while in BUSY, release, complete that word → nothing is pushed; the next full word is captured normally.
